// File: rtl/ctrlpid_pkg.sv
// Shared definitions for the multi-channel PID controller: FSM states,
// configuration select codes, the term-off gain code and the clamping adder.
package ctrlpid_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_PTERM = 3'd2,
    ST_ITERM = 3'd3,
    ST_DTERM = 3'd4,
    ST_WRITE = 3'd5,
    ST_WAIT  = 3'd6
  } state_t;

  localparam logic [1:0] SEL_KP = 2'd0;
  localparam logic [1:0] SEL_KI = 2'd1;
  localparam logic [1:0] SEL_KD = 2'd2;
  localparam logic [1:0] SEL_EN = 2'd3;

  localparam int unsigned GAIN_W = 6;
  // Most negative gain code switches its term off entirely
  localparam logic signed [GAIN_W-1:0] K_OFF = {1'b1, {(GAIN_W-1){1'b0}}};

  // Add a term to the accumulator and clamp to the symmetric bound
  function automatic longint sat_add(input longint acc, input longint term,
                                     input longint lim);
    longint s;
    longint r;
    s = acc + term;
    r = s;
    if (s > lim) r = lim;
    else if (s < -lim) r = -lim;
    return r;
  endfunction

endpackage

// File: rtl/ctrlpid_shift.sv
// Signed bidirectional shift by gain K plus a fixed offset; left-shift
// overflow saturates to the signed extreme, K_OFF yields zero.
module ctrlpid_shift
  import ctrlpid_pkg::*;
#(
  parameter int unsigned W   = 34,
  parameter int unsigned CW  = 6,
  parameter int          OFS = 0
) (
  input  logic signed [W-1:0]  x,
  input  logic signed [CW-1:0] k,
  output logic signed [W-1:0]  y
);

  localparam logic signed [W-1:0] MAXV = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};

  int                 amt;
  logic signed [W-1:0] shl;
  logic signed [W-1:0] back;

  always_comb begin
    amt  = int'(k) + OFS;
    shl  = '0;
    back = '0;
    y    = '0;
    if (k == K_OFF) begin
      y = '0;
    end else if (amt < 0) begin
      y = x >>> (-amt);
    end else if (amt >= int'(W)) begin
      y = (x == '0) ? '0 : (x[W-1] ? MINV : MAXV);
    end else begin
      // Overflow shows up as a value that does not survive the round trip
      shl  = x <<< amt;
      back = shl >>> amt;
      y    = (back != x) ? (x[W-1] ? MINV : MAXV) : shl;
    end
  end

endmodule

// File: rtl/ctrlpid_mc.sv
// Time-multiplexed multi-channel incremental PID controller with per-channel
// gains/enables. Define CTRLPID_DEADBAND_EN to zero errors within DEADBAND.
module ctrlpid_mc
  import ctrlpid_pkg::*;
#(
  parameter int unsigned AW        = 2,
  parameter int unsigned PSC       = 15,
  parameter int unsigned EW        = 24,
  parameter int unsigned PW        = 32,
  parameter int unsigned OW        = 12,
  parameter int unsigned CW        = 6,
  parameter int unsigned FP        = 9,
  parameter int unsigned PRECISION = 1,
  parameter int unsigned LIMIT     = 'hFF0,
  parameter int unsigned DEADBAND  = 0
) (
  input  logic                     clk_pid,
  input  logic                     reset,
  output logic [AW-1:0]            a,
  input  logic [EW-1:0]            error,
  input  logic                     cfg_we,
  input  logic [AW-1:0]            cfg_ch,
  input  logic [1:0]               cfg_sel,
  input  logic [CW-1:0]            cfg_data,
  output logic [OW-1:0]            m_k_out,
  output logic [AW-1:0]            m_k_ch,
  output logic                     m_k_valid,
  output logic [(2**AW)*OW-1:0]    out_all
);

  localparam int unsigned NCH = 2**AW;
  localparam int unsigned SW  = PSC - AW;
  localparam int unsigned TW  = PW + 2;
  localparam longint      LIM = longint'(LIMIT);

  if (SW < 3) begin : g_bad_slot
    $error("ctrlpid_mc: slot length must be at least 8 clocks");
  end
  if (CW != GAIN_W) begin : g_bad_cw
    $error("ctrlpid_mc: CW must match the package gain width");
  end
  if (DEADBAND >= 2**(EW-1)) begin : g_bad_deadband
    $error("ctrlpid_mc: DEADBAND exceeds the error range");
  end

  logic [PSC-1:0]       uswitch;
  logic [SW-1:0]        slot_cnt;
  state_t               state;

  logic signed [CW-1:0] kp_r [NCH];
  logic signed [CW-1:0] ki_r [NCH];
  logic signed [CW-1:0] kd_r [NCH];
  logic [NCH-1:0]       en_r;
  logic signed [PW-1:0] u_r  [NCH];
  logic signed [PW-1:0] e1_r [NCH];
  logic signed [PW-1:0] e2_r [NCH];

  logic signed [CW-1:0] wkp, wki, wkd;
  logic signed [PW-1:0] wu, we0, we1, we2;
  logic signed [PW-1:0] e_smp;
  logic signed [TW-1:0] dp, di, dd, tp, ti, td;

  assign a        = uswitch[PSC-1:SW];
  assign slot_cnt = uswitch[SW-1:0];

`ifdef CTRLPID_DEADBAND_EN
  // One extra bit so the most negative error has a representable magnitude
  logic signed [EW:0] err_x, err_abs;
  assign err_x   = (EW+1)'($signed(error));
  assign err_abs = err_x[EW] ? -err_x : err_x;
  assign e_smp   = (err_abs <= $signed((EW+1)'(DEADBAND))) ? '0 : PW'($signed(error));
`else
  assign e_smp = PW'($signed(error));
`endif

  assign dp = TW'(we0) - TW'(we1);
  assign di = TW'(we0) + TW'(we1);
  assign dd = TW'(we0) - (TW'(we1) <<< 1) + TW'(we2);

  ctrlpid_shift #(.W(TW), .CW(CW), .OFS(int'(PRECISION))) u_shift_p (
    .x(dp), .k(wkp), .y(tp)
  );
  ctrlpid_shift #(.W(TW), .CW(CW), .OFS(int'(PRECISION) - 1 - int'(FP))) u_shift_i (
    .x(di), .k(wki), .y(ti)
  );
  ctrlpid_shift #(.W(TW), .CW(CW), .OFS(int'(PRECISION) + int'(FP))) u_shift_d (
    .x(dd), .k(wkd), .y(td)
  );

  // Slot sequencer, register file and output registers
  always_ff @(posedge clk_pid) begin
    if (reset) begin
      uswitch   <= '0;
      state     <= ST_IDLE;
      m_k_out   <= '0;
      m_k_ch    <= '0;
      m_k_valid <= 1'b0;
      out_all   <= '0;
      en_r      <= '0;
      wkp       <= K_OFF;
      wki       <= K_OFF;
      wkd       <= K_OFF;
      wu        <= '0;
      we0       <= '0;
      we1       <= '0;
      we2       <= '0;
      for (int i = 0; i < int'(NCH); i++) begin
        kp_r[i] <= K_OFF;
        ki_r[i] <= K_OFF;
        kd_r[i] <= K_OFF;
        u_r[i]  <= '0;
        e1_r[i] <= '0;
        e2_r[i] <= '0;
      end
    end else begin
      uswitch   <= uswitch + PSC'(1);
      m_k_valid <= 1'b0;
      if (cfg_we) begin
        case (cfg_sel)
          SEL_KP:  kp_r[cfg_ch] <= cfg_data;
          SEL_KI:  ki_r[cfg_ch] <= cfg_data;
          SEL_KD:  kd_r[cfg_ch] <= cfg_data;
          default: en_r[cfg_ch] <= cfg_data[0];
        endcase
      end
      case (state)
        ST_IDLE: state <= ST_LOAD;
        ST_LOAD: begin
          // A disabled channel runs with zeroed history and all terms off
          if (en_r[a]) begin
            wkp <= kp_r[a];
            wki <= ki_r[a];
            wkd <= kd_r[a];
            wu  <= u_r[a];
            we0 <= e_smp;
            we1 <= e1_r[a];
            we2 <= e2_r[a];
          end else begin
            wkp <= K_OFF;
            wki <= K_OFF;
            wkd <= K_OFF;
            wu  <= '0;
            we0 <= '0;
            we1 <= '0;
            we2 <= '0;
          end
          state <= ST_PTERM;
        end
        ST_PTERM: begin
          wu    <= PW'(sat_add(longint'(wu), longint'(tp), LIM));
          state <= ST_ITERM;
        end
        ST_ITERM: begin
          wu    <= PW'(sat_add(longint'(wu), longint'(ti), LIM));
          state <= ST_DTERM;
        end
        ST_DTERM: begin
          wu    <= PW'(sat_add(longint'(wu), longint'(td), LIM));
          state <= ST_WRITE;
        end
        ST_WRITE: begin
          u_r[a]                <= wu;
          e1_r[a]               <= we0;
          e2_r[a]               <= we1;
          m_k_out               <= wu[PRECISION+OW-1:PRECISION];
          m_k_ch                <= a;
          m_k_valid             <= 1'b1;
          out_all[a*OW +: OW]   <= wu[PRECISION+OW-1:PRECISION];
          state                 <= ST_WAIT;
        end
        ST_WAIT: if (slot_cnt == '1) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
